// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder: oversamples ss/sck/mosi on clk and assembles MSB-first bytes.
// It answers with status_in on the first byte of a frame, then with fabric-supplied tx_data.
module spi_slave_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  input  logic [7:0]       status_in,
  input  logic [7:0]       tx_data,
  output logic             miso,
  output logic             miso_oe,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             tx_req,
  output logic             first_byte,
  output logic [CNT_W-1:0] byte_count,
  output logic             frame_end,
  output logic             frame_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_d;
  logic                   r_sck_d;

  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_rx_sr;
  logic [7:0]       r_tx_sr;
  logic             r_seen_rise;
  logic             r_miso_oe;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_tx_req;
  logic             r_first_byte;
  logic [CNT_W-1:0] r_byte_count;
  logic             r_frame_end;
  logic             r_frame_err;

  logic w_ss_s;
  logic w_sck_s;
  logic w_mosi_s;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sck_rise;
  logic w_sck_fall;

  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall  = r_ss_d & ~w_ss_s;
  assign w_ss_rise  = ~r_ss_d & w_ss_s;
  assign w_sck_rise = ~r_sck_d & w_sck_s;
  assign w_sck_fall = r_sck_d & ~w_sck_s;

  // ss idles high so the synchroniser clears to 1 and reset cannot fake a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sck_d     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_d      <= w_ss_s;
      r_sck_d     <= w_sck_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_rx_sr      <= 8'd0;
      r_tx_sr      <= 8'd0;
      r_seen_rise  <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_first_byte <= 1'b0;
      r_byte_count <= '0;
      r_frame_end  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_first_byte <= 1'b0;
      r_frame_end  <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state      <= ACTIVE;
            r_bit_cnt    <= 3'd0;
            r_byte_count <= '0;
            r_tx_sr      <= status_in;
            r_seen_rise  <= 1'b0;
            r_miso_oe    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state     <= IDLE;
            r_frame_end <= 1'b1;
            r_frame_err <= (r_bit_cnt != 3'd0);
            r_miso_oe   <= 1'b0;
            r_tx_sr     <= 8'd0;
          end else if (w_sck_rise) begin
            r_rx_sr     <= {r_rx_sr[6:0], w_mosi_s};
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_seen_rise <= 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_data    <= {r_rx_sr[6:0], w_mosi_s};
              r_rx_valid   <= 1'b1;
              r_tx_req     <= 1'b1;
              r_first_byte <= (r_byte_count == '0);
              if (r_byte_count != '1)
                r_byte_count <= r_byte_count + CNT_ONE;
            end
          end else if (w_sck_fall && r_seen_rise) begin
            // bit_cnt wraps to 0 after the eighth rise, marking the byte boundary
            if (r_bit_cnt == 3'd0)
              r_tx_sr <= tx_data;
            else
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso       = r_tx_sr[7];
  assign miso_oe    = r_miso_oe;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_req     = r_tx_req;
  assign first_byte = r_first_byte;
  assign byte_count = r_byte_count;
  assign frame_end  = r_frame_end;
  assign frame_err  = r_frame_err;

endmodule
